// File: rtl/conv32_8_arb.sv
// Round-robin arbiter sharing one 32-to-8 serializer lane among four word sources.
// Optional CONV_COMMA_IDLE_EN: drive K28.5 (8'hBC) on out_data while idle or in reset.
module conv32_8_arb (
  input  logic         clk_4f,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [127:0] in_data,
  output logic [3:0]   ack,
  output logic [7:0]   out_data,
  output logic         out,
  output logic [1:0]   gnt_id,
  output logic         busy
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 32;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

`ifdef CONV_COMMA_IDLE_EN
  localparam logic [7:0] IDLE_BYTE = 8'hBC;
`else
  localparam logic [7:0] IDLE_BYTE = 8'h00;
`endif

  logic [0:0]    state, state_nxt;
  logic [DW-1:0] sh, sh_nxt;
  logic [1:0]    cnt, cnt_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [1:0]    gnt_nxt;
  logic [1:0]    winner;
  logic          found;
  logic          cap_opp;
  logic [6:0]    base;
  logic [DW-1:0] word_sel;

  // First pending request at or after ptr, wrapping 3 -> 0
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[ptr + 2'(k)]) begin
        winner = ptr + 2'(k);
        found  = 1'b1;
      end
    end
  end

  assign base     = {winner, 5'b00000};
  assign word_sel = in_data[base +: DW];
  assign cap_opp  = (state == S_IDLE) || (cnt == 2'd3);

  // Next-state and ack decode
  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt_id;
    ack       = 4'b0000;

    if (state == S_SEND) begin
      sh_nxt  = {sh[DW-9:0], 8'h00};
      cnt_nxt = cnt + 2'd1;
      if (cnt == 2'd3) begin
        state_nxt = S_IDLE;
      end
    end

    if (cap_opp && found) begin
      ack       = reset ? (4'b0001 << winner) : 4'b0000;
      sh_nxt    = word_sel;
      gnt_nxt   = winner;
      cnt_nxt   = 2'd0;
      ptr_nxt   = winner + 2'd1;
      state_nxt = S_SEND;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state  <= S_IDLE;
      sh     <= '0;
      cnt    <= 2'd0;
      ptr    <= 2'd0;
      gnt_id <= 2'd0;
    end else begin
      state  <= state_nxt;
      sh     <= sh_nxt;
      cnt    <= cnt_nxt;
      ptr    <= ptr_nxt;
      gnt_id <= gnt_nxt;
    end
  end

  assign out      = (state == S_SEND);
  assign busy     = (state == S_SEND);
  assign out_data = (state == S_SEND) ? sh[DW-1:DW-8] : IDLE_BYTE;

endmodule

// File: tb/tb_conv32_8_arb.sv
// Directed self-checking bench for conv32_8_arb.
module tb_conv32_8_arb;

`ifdef CONV_COMMA_IDLE_EN
  localparam logic [7:0] IDLE_EXP = 8'hBC;
`else
  localparam logic [7:0] IDLE_EXP = 8'h00;
`endif

  logic         clk_4f = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] in_data;
  logic [3:0]   ack;
  logic [7:0]   out_data;
  logic         out;
  logic [1:0]   gnt_id;
  logic         busy;

  int checks = 0;
  int errors = 0;

  conv32_8_arb dut (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .req      (req),
    .in_data  (in_data),
    .ack      (ack),
    .out_data (out_data),
    .out      (out),
    .gnt_id   (gnt_id),
    .busy     (busy)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic set_word(input int i, input logic [31:0] val);
    in_data[32*i +: 32] = val;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out"},  32'(out),      32'h0);
    check({tag, "_data"}, 32'(out_data), 32'(IDLE_EXP));
    check({tag, "_busy"}, 32'(busy),     32'h0);
  endtask

  task automatic check_byte(input string tag, input logic [7:0] b, input logic [1:0] g);
    check({tag, "_out"},  32'(out),      32'h1);
    check({tag, "_data"}, 32'(out_data), 32'(b));
    check({tag, "_gnt"},  32'(gnt_id),   32'(g));
  endtask

  initial begin
    logic [7:0] deadbeef [4];
    logic [7:0] cafef00d [4];
    deadbeef = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    cafef00d = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};

    reset   = 1'b0;
    req     = 4'hF;
    in_data = '0;

    // Reset held with all sources requesting
    for (int i = 0; i < 3; i++) begin
      edge_step();
      check("rst_ack", 32'(ack), 32'h0);
      check_idle("rst");
    end

    // Release: requester 0 has top priority, then drop before the edge
    reset = 1'b1;
    #1;
    check("rel_ack", 32'(ack), 32'h1);
    req = 4'h0;
    #1;
    check("drop_ack", 32'(ack), 32'h0);
    edge_step();
    check_idle("drop");

    // Single word from source 2
    set_word(2, 32'hDEADBEEF);
    req = 4'b0100;
    #1;
    check("sw_ack", 32'(ack), 32'b0100);
    for (int b = 0; b < 4; b++) begin
      edge_step();
      req = 4'h0;
      if (b == 3) begin
        // Late request with ptr at 3 wraps to source 0
        set_word(0, 32'hCAFEF00D);
        req = 4'b0001;
        #1;
        check("wrap_ack", 32'(ack), 32'b0001);
      end else begin
        #1;
        check("sw_noack", 32'(ack), 32'h0);
      end
      check_byte("sw", deadbeef[b], 2'd2);
    end
    for (int b = 0; b < 4; b++) begin
      edge_step();
      req = 4'h0;
      check_byte("wrap", cafef00d[b], 2'd0);
    end
    edge_step();
    check_idle("post_wrap");

    // Mid-word reset after byte 1 (ptr now 1)
    set_word(1, 32'hA1B2C3D4);
    req = 4'b0010;
    #1;
    check("mr_ack", 32'(ack), 32'b0010);
    edge_step();
    req = 4'h0;
    check_byte("mr_b0", 8'hA1, 2'd1);
    edge_step();
    check_byte("mr_b1", 8'hB2, 2'd1);
    reset = 1'b0;
    req   = 4'hF;
    #1;
    check("mr_rst_ack", 32'(ack), 32'h0);
    edge_step();
    check_idle("mr_rst1");
    edge_step();
    check_idle("mr_rst2");

    // Round robin with all four requesting continuously
    set_word(0, 32'h11111111);
    set_word(1, 32'h22222222);
    set_word(2, 32'h33333333);
    set_word(3, 32'h44444444);
    reset = 1'b1;
    #1;
    check("rr_first_ack", 32'(ack), 32'h1);
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) begin
        edge_step();
        check_byte("rr", 8'(((w % 4) + 1) * 17), 2'(w % 4));
        if (b == 3) begin
          check("rr_ack", 32'(ack), 32'(4'b0001 << ((w + 1) % 4)));
        end else begin
          check("rr_noack", 32'(ack), 32'h0);
        end
      end
    end
    req = 4'h0;
    #1;
    edge_step();
    check_idle("rr_end");
    edge_step();
    check_idle("idle_tail");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv32_8_arb.md
# conv32_8_arb

Round-robin scheduler that shares one 32-to-8 byte-serializer lane among four 32-bit word sources. It runs in the `clk_4f` domain, accepts one word per grant through a req/ack handshake, and emits the word MSB-byte-first over four consecutive cycles with a byte-valid flag. It sits between the per-lane 32-bit producers and the 8-bit serial link path, and replaces per-source converters when sources must share one link.

## Interface
- `NREQ`, 4: number of requesters; fixed at 4 in this revision.
- `DW`, 32: word width; fixed at 32, serialized as four bytes.
- `clk_4f` in 1: single clock, 4x word rate.
- `reset` in 1: synchronous, active-low. Sampled only on the `clk_4f` rising edge.
- `req` in 4: `req[i]` high means source i holds a valid word on its slice of `in_data`.
- `in_data` in 128: source i word at `in_data[32*i+31:32*i]`.
- `ack` out 4: one-hot and combinational; `ack[i]` high means source i's word is captured at this edge.
- `out_data` out 8: serialized byte.
- `out` out 1: byte valid.
- `gnt_id` out 2: index of the source whose word is currently on `out_data`.
- `busy` out 1: high while in SEND.

## Operation
- **States:** IDLE and SEND.
- **Registers:**
  - 32-bit shift register `sh`.
  - 2-bit byte counter `cnt`.
  - 2-bit round-robin pointer `ptr`.
  - `gnt_id`.
- **Capture opportunity:** the cycle is a capture opportunity when `state==IDLE`, or when `state==SEND && cnt==3`.
- **Winner selection:** the winner is the first set bit of `req` searched from `ptr` upward, wrapping from 3 to 0.
- **`ack`:** `ack[winner]=1` only in a capture opportunity with `req!=0` and `reset==1`. Otherwise `ack=0`.
- **On the capture edge:**
  - `sh<=in_data[winner]`, `gnt_id<=winner`, `cnt<=0`, `state<=SEND`.
  - `ptr<=winner+1` (mod 4).
- **SEND:**
  - `out=1`, `out_data=sh[31:24]`, and `sh` shifts left 8 each edge.
  - `cnt` increments each edge.
  - At `cnt==3`, the next state is SEND on a new capture, else IDLE.
- **IDLE:**
  - `out=0`.
  - `out_data=8'h00` (see Configuration).
  - `gnt_id` holds its last value.
- **Source contract:** a source must keep `req` and its data stable until it samples `ack` high. It may drop `req` at any time before `ack`; a dropped request is not served.
- **Reset values** (while `reset==0` at an edge):
  - state IDLE, `cnt=0`, `sh=0`, `ptr=0`, `gnt_id=0`.
  - Hence `out=0`, `out_data=8'h00`, `busy=0`.
  - `ack` is forced 0 combinationally while `reset==0`.
- **Reset mid-word:** the word in flight is discarded and `out` falls in the cycle after the reset edge. No ack is issued on that edge. After release, requester 0 has top priority.
- **Simultaneous requests:** exactly one ack per capture opportunity. Losers keep `req` asserted and are served in rotating order, so none waits more than 3 words.

## Timing
- **Latency:** with the block in IDLE and `req[i]` rising before edge E, `ack[i]` is high in the cycle ending at E. Byte 0 (`[31:24]`) is valid in cycle E..E+1; bytes 1, 2 and 3 follow in the next three cycles.
- **Throughput:** back-to-back words have no bubble. With a request pending during byte 3, byte 0 of the next word appears in the next cycle. Peak rate is 1 word per 4 `clk_4f` cycles, matching `clk_f` word rate.
- **Combinational paths:** `ack` depends on `req`, state, `cnt`, `ptr` and `reset` only. No path runs from `in_data` to any output.
- **Registered outputs:** `out_data`, `out`, `gnt_id` and `busy` are registered or decoded from registered state only.

## Configuration
- **`CONV_COMMA_IDLE_EN`:**
  - Defined: in IDLE and while in reset, `out_data=8'hBC` (K28.5 comma) with `out=0`. The reset value of `out_data` becomes `8'hBC`.
  - Undefined: idle/reset `out_data=8'h00`.
- Behaviour in SEND is identical either way.

## Test plan
- **Reset:** hold `reset=0` 3 cycles with `req=4'hF` -> `ack=0`, `out=0`, `out_data=00`, `busy=0` throughout; after release, first `ack=4'b0001`.
- **Single word:** `req=4'b0100`, word2=`32'hDEADBEEF` -> `ack[2]` for one cycle, then `out=1` with `DE,AD,BE,EF` on 4 consecutive cycles, `gnt_id=2`, then `out=0`.
- **Round robin:** all four requesting continuously with words `11111111`, `22222222`, `33333333`, `44444444` -> grants 0,1,2,3,0 and 20 consecutive valid bytes with no gap.
- **Mid-word reset:** reset asserted after byte 1 of `A1B2C3D4` -> next cycle `out=0`; `C3`/`D4` never appear; post-release grant restarts at requester 0.
- **Late request / wrap:** `ptr=3`, only `req[0]` high during byte 3 -> `ack[0]` at the byte-3 edge, next word starts immediately.
- **Comma build:** with `CONV_COMMA_IDLE_EN` defined, idle -> `out_data=BC`, `out=0`; without it, `out_data=00`.
